// File: rtl/sccb_slave.sv
// -----------------------------------------------------------------------------
// sccb_slave -- SCCB/I2C write responder for the OV5640 configuration link.
//
// Oversamples sclk/sda on clk_100, decodes device-address / 16-bit register
// address / data-byte transactions, ACKs matching bytes and presents every
// decoded register write as a one-cycle strobe. Sequential data bytes write
// sequential (post-incremented) addresses.
//
// Optional feature macro: SCCB_SLAVE_READ_EN
//   defined   : device byte {DEV_ADDR,1} is ACKed and bytes are read out from
//               rd_data, with rd_addr giving the address being read.
//   undefined : rd_addr/rd_data ports are absent and the read byte is NACKed.
//
// Ports:
//   clk_100   in     system clock, 100 MHz
//   rst_100   in     asynchronous active-low reset
//   sclk      in     SCCB clock from the master (asynchronous)
//   sda       inout  open-drain data, driven only to 0 or Z
//   wr_valid  out    one-cycle strobe, wr_addr/wr_data valid
//   wr_addr   out    register address of the current write
//   wr_data   out    data byte of the current write
//   cnt_wr    out    number of completed writes (wraps)
//   err       out    one-cycle pulse when a byte is cut by START/STOP
//   rd_addr   out    (read build) address of the byte being read
//   rd_data   in     (read build) read byte, sampled when the byte is loaded
//   busy      out    high from START to STOP
// -----------------------------------------------------------------------------
module sccb_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h3C
) (
  input  logic        clk_100,
  input  logic        rst_100,
  input  logic        sclk,
  inout  wire         sda,
  output logic        wr_valid,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [15:0] cnt_wr,
  output logic        err,
`ifdef SCCB_SLAVE_READ_EN
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
`endif
  output logic        busy
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV       = 4'd1,
    ST_ACK_DEV   = 4'd2,
    ST_RA_H      = 4'd3,
    ST_ACK_RA_H  = 4'd4,
    ST_RA_L      = 4'd5,
    ST_ACK_RA_L  = 4'd6,
    ST_DATA      = 4'd7,
    ST_ACK_DATA  = 4'd8,
    ST_RD        = 4'd9,
    ST_RD_ACK    = 4'd10,
    ST_WAIT_STOP = 4'd11
  } state_e;

  // Synchronizer and history registers (idle bus level is high)
  logic scl_m_q, scl_s_q, scl_h_q;
  logic sda_m_q, sda_s_q, sda_h_q;

  // Protocol state
  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic        byte_rdy_q, byte_rdy_d;   // 8 bits in, waiting for the ACK edge
  logic        rnw_q, rnw_d;
  logic [15:0] addr_q, addr_d;
  logic        sda_oe_q, sda_oe_d;

  // Output registers
  logic        wr_valid_q, wr_valid_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [15:0] cnt_wr_q, cnt_wr_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

`ifdef SCCB_SLAVE_READ_EN
  logic [7:0]  tx_q, tx_d;
  logic        mack_q, mack_d;
`endif

  // Decoded bus events
  logic       scl_rise_s, scl_fall_s, start_s, stop_s, in_byte_s;
  logic [7:0] byte_s;

  assign scl_rise_s = scl_s_q & ~scl_h_q;
  assign scl_fall_s = ~scl_s_q & scl_h_q;
  assign start_s    = scl_s_q & scl_h_q & sda_h_q & ~sda_s_q;
  assign stop_s     = scl_s_q & scl_h_q & ~sda_h_q & sda_s_q;
  assign byte_s     = {sh_q[6:0], sda_s_q};
  assign in_byte_s  = (state_q == ST_DEV) || (state_q == ST_RA_H) ||
                      (state_q == ST_RA_L) || (state_q == ST_DATA) ||
                      (state_q == ST_RD);

  // Two-stage synchronizer plus one history stage for sclk and sda
  always_ff @(posedge clk_100 or negedge rst_100) begin
    if (!rst_100) begin
      scl_m_q <= 1'b1;
      scl_s_q <= 1'b1;
      scl_h_q <= 1'b1;
      sda_m_q <= 1'b1;
      sda_s_q <= 1'b1;
      sda_h_q <= 1'b1;
    end else begin
      scl_m_q <= sclk;
      scl_s_q <= scl_m_q;
      scl_h_q <= scl_s_q;
      sda_m_q <= sda;
      sda_s_q <= sda_m_q;
      sda_h_q <= sda_s_q;
    end
  end

  // Next-state, datapath and output decode for the transaction FSM
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    byte_rdy_d = byte_rdy_q;
    rnw_d      = rnw_q;
    addr_d     = addr_q;
    sda_oe_d   = sda_oe_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    cnt_wr_d   = cnt_wr_q;
    busy_d     = busy_q;
    err_d      = 1'b0;
`ifdef SCCB_SLAVE_READ_EN
    tx_d       = tx_q;
    mack_d     = mack_q;
`endif

    // START/STOP take priority over bit handling in the same cycle.
    if (start_s || stop_s) begin
      err_d      = in_byte_s && (bit_cnt_q != 3'd0);
      bit_cnt_d  = 3'd0;
      byte_rdy_d = 1'b0;
      sda_oe_d   = 1'b0;
      if (start_s) begin
        state_d = ST_DEV;
        busy_d  = 1'b1;
      end else begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE, ST_WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end

        ST_DEV, ST_RA_H, ST_RA_L, ST_DATA: begin
          if (scl_rise_s && !byte_rdy_q) begin
            sh_d      = byte_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              // Device byte decides here whether this slave answers at all.
              if (state_q != ST_DEV) begin
                byte_rdy_d = 1'b1;
              end else if (byte_s == {DEV_ADDR, 1'b0}) begin
                rnw_d      = 1'b0;
                byte_rdy_d = 1'b1;
`ifdef SCCB_SLAVE_READ_EN
              end else if (byte_s == {DEV_ADDR, 1'b1}) begin
                rnw_d      = 1'b1;
                byte_rdy_d = 1'b1;
`endif
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end else begin
              byte_rdy_d = 1'b0;
            end
          end else if (scl_fall_s && byte_rdy_q) begin
            // Falling edge after bit 8: start driving ACK and commit the byte.
            byte_rdy_d = 1'b0;
            sda_oe_d   = 1'b1;
            case (state_q)
              ST_DEV: begin
                state_d = ST_ACK_DEV;
              end
              ST_RA_H: begin
                addr_d  = {sh_q, addr_q[7:0]};
                state_d = ST_ACK_RA_H;
              end
              ST_RA_L: begin
                addr_d  = {addr_q[15:8], sh_q};
                state_d = ST_ACK_RA_L;
              end
              ST_DATA: begin
                wr_valid_d = 1'b1;
                wr_addr_d  = addr_q;
                wr_data_d  = sh_q;
                cnt_wr_d   = cnt_wr_q + 16'd1;
                addr_d     = addr_q + 16'd1;
                state_d    = ST_ACK_DATA;
              end
              default: begin
                sda_oe_d = 1'b0;
                state_d  = ST_WAIT_STOP;
              end
            endcase
          end else begin
            sh_d = sh_q;
          end
        end

        ST_ACK_DEV, ST_ACK_RA_H, ST_ACK_RA_L, ST_ACK_DATA: begin
          if (scl_fall_s) begin
            // ACK clock ends: release the line and move to the next byte.
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            case (state_q)
              ST_ACK_DEV: begin
                if (rnw_q) begin
`ifdef SCCB_SLAVE_READ_EN
                  tx_d     = rd_data;
                  sda_oe_d = ~rd_data[7];
                  state_d  = ST_RD;
`else
                  state_d  = ST_WAIT_STOP;
`endif
                end else begin
                  state_d = ST_RA_H;
                end
              end
              ST_ACK_RA_H: state_d = ST_RA_L;
              ST_ACK_RA_L: state_d = ST_DATA;
              ST_ACK_DATA: state_d = ST_DATA;
              default:     state_d = ST_WAIT_STOP;
            endcase
          end else begin
            sda_oe_d = 1'b1;
          end
        end

`ifdef SCCB_SLAVE_READ_EN
        ST_RD: begin
          if (scl_fall_s) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              // Last bit clocked out: hand the line to the master for ACK.
              sda_oe_d = 1'b0;
              state_d  = ST_RD_ACK;
            end else begin
              tx_d     = {tx_q[6:0], 1'b0};
              sda_oe_d = ~tx_q[6];
            end
          end else begin
            tx_d = tx_q;
          end
        end

        ST_RD_ACK: begin
          if (scl_rise_s) begin
            mack_d = ~sda_s_q;
            // Advance early so rd_addr is settled before rd_data is sampled.
            if (!sda_s_q) begin
              addr_d = addr_q + 16'd1;
            end else begin
              addr_d = addr_q;
            end
          end else if (scl_fall_s) begin
            if (mack_q) begin
              tx_d      = rd_data;
              sda_oe_d  = ~rd_data[7];
              bit_cnt_d = 3'd0;
              state_d   = ST_RD;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_WAIT_STOP;
            end
          end else begin
            mack_d = mack_q;
          end
        end
`else
        ST_RD, ST_RD_ACK: begin
          sda_oe_d = 1'b0;
          state_d  = ST_WAIT_STOP;
        end
`endif

        default: begin
          sda_oe_d = 1'b0;
          state_d  = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset releases sda asynchronously
  always_ff @(posedge clk_100 or negedge rst_100) begin
    if (!rst_100) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      sh_q       <= 8'd0;
      byte_rdy_q <= 1'b0;
      rnw_q      <= 1'b0;
      addr_q     <= 16'd0;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 16'd0;
      wr_data_q  <= 8'd0;
      cnt_wr_q   <= 16'd0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef SCCB_SLAVE_READ_EN
      tx_q       <= 8'd0;
      mack_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      byte_rdy_q <= byte_rdy_d;
      rnw_q      <= rnw_d;
      addr_q     <= addr_d;
      sda_oe_q   <= sda_oe_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cnt_wr_q   <= cnt_wr_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
`ifdef SCCB_SLAVE_READ_EN
      tx_q       <= tx_d;
      mack_q     <= mack_d;
`endif
    end
  end

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cnt_wr   = cnt_wr_q;
  assign busy     = busy_q;
  assign err      = err_q;
`ifdef SCCB_SLAVE_READ_EN
  assign rd_addr  = addr_q;
`endif

endmodule

// File: tb/tb_sccb_slave.sv
module tb_sccb_slave;

  localparam int T = 20;  // SCL half-period in clk_100 cycles

  logic        clk_100 = 1'b0;
  logic        rst_100;
  logic        sclk;
  logic        m_sda_lo;
  wire         sda_w;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] cnt_wr;
  logic        busy;
  logic        err;
`ifdef SCCB_SLAVE_READ_EN
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
`endif

  pullup (sda_w);
  assign sda_w = m_sda_lo ? 1'b0 : 1'bz;

  always #5 clk_100 = ~clk_100;

  sccb_slave dut (
    .clk_100  (clk_100),
    .rst_100  (rst_100),
    .sclk     (sclk),
    .sda      (sda_w),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cnt_wr   (cnt_wr),
    .err      (err),
`ifdef SCCB_SLAVE_READ_EN
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
`endif
    .busy     (busy)
  );

  // Scoreboard: expected writes pushed by stimulus, observed writes by monitor
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  int          err_seen = 0;
  int          overlap_seen = 0;
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic [15:0] exp_cnt;

  always @(negedge clk_100) begin
    if (wr_valid === 1'b1) obs_q.push_back({wr_addr, wr_data});
    if (err === 1'b1) err_seen++;
    if (wr_valid === 1'b1 && err === 1'b1) overlap_seen++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_100);
  endtask

  task automatic settle();
    @(negedge clk_100);
  endtask

  task automatic m_start();
    wait_cyc(T/2); m_sda_lo = 1'b0;
    wait_cyc(T/2); sclk = 1'b1;
    wait_cyc(T);   m_sda_lo = 1'b1;
    wait_cyc(T);   sclk = 1'b0;
  endtask

  task automatic m_bit(input logic b);
    wait_cyc(T/2); m_sda_lo = ~b;
    wait_cyc(T/2); sclk = 1'b1;
    wait_cyc(T);   sclk = 1'b0;
  endtask

  task automatic m_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) m_bit(b[i]);
    wait_cyc(T/2); m_sda_lo = 1'b0;
    wait_cyc(T/2); sclk = 1'b1;
    wait_cyc(T/2); ack = (sda_w === 1'b0);
    wait_cyc(T/2); sclk = 1'b0;
  endtask

  task automatic m_stop();
    wait_cyc(T/2); m_sda_lo = 1'b1;
    wait_cyc(T/2); sclk = 1'b1;
    wait_cyc(T);   m_sda_lo = 1'b0;
    wait_cyc(T);
  endtask

`ifdef SCCB_SLAVE_READ_EN
  task automatic m_read(input logic give_ack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      wait_cyc(T/2); m_sda_lo = 1'b0;
      wait_cyc(T/2); sclk = 1'b1;
      wait_cyc(T/2); b[i] = (sda_w !== 1'b0);
      wait_cyc(T/2); sclk = 1'b0;
    end
    wait_cyc(T/2); m_sda_lo = give_ack;
    wait_cyc(T/2); sclk = 1'b1;
    wait_cyc(T);   sclk = 1'b0;
  endtask
`endif

  task automatic test_reset();
    rst_100 = 1'b1; sclk = 1'b1; m_sda_lo = 1'b0;
    exp_cnt = 16'd0;
    #2 rst_100 = 1'b0;
    wait_cyc(4); settle();
    chk_cnt++;
    if ({wr_valid, wr_addr, wr_data, cnt_wr, busy, err} !== 43'd0)
      $display("FAIL reset_outputs got %h want 0", {wr_valid, wr_addr, wr_data, cnt_wr, busy, err});
    else pass_cnt++;
    chk_cnt++;
    if (sda_w !== 1'b1) $display("FAIL reset_sda got %b want 1", sda_w); else pass_cnt++;
    rst_100 = 1'b1;
    wait_cyc(10); settle();
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_basic_write();
    logic a0, a1, a2, a3;
    logic [23:0] e, o;
    exp_q.push_back({16'h3103, 8'h11}); exp_cnt = exp_cnt + 16'd1;
    m_start();
    m_byte(8'h78, a0); m_byte(8'h31, a1); m_byte(8'h03, a2); m_byte(8'h11, a3);
    settle();
    chk_cnt++;
    if ({a0, a1, a2, a3} !== 4'b1111) $display("FAIL basic_acks got %b want 1111", {a0, a1, a2, a3}); else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL basic_busy_mid got %b want 1", busy); else pass_cnt++;
    m_stop(); settle();
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL basic_busy_after got %b want 0", busy); else pass_cnt++;
    chk_cnt++;
    if (cnt_wr !== exp_cnt) $display("FAIL basic_cnt got %h want %h", cnt_wr, exp_cnt); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs_q.size() == 0) $display("FAIL basic_write missing want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL basic_write got %h want %h", o, e); else pass_cnt++;
      end
    end
    chk_cnt++;
    if (obs_q.size() != 0) $display("FAIL basic_extra got %0d want 0", obs_q.size()); else pass_cnt++;
  endtask

  task automatic test_bad_dev();
    logic a0, a1, a2, a3;
    int e0;
    e0 = err_seen;
    m_start();
    m_byte(8'h7A, a0); m_byte(8'h31, a1); m_byte(8'h03, a2); m_byte(8'h11, a3);
    m_stop(); settle();
    chk_cnt++;
    if ({a0, a1, a2, a3} !== 4'b0000) $display("FAIL baddev_acks got %b want 0000", {a0, a1, a2, a3}); else pass_cnt++;
    chk_cnt++;
    if (cnt_wr !== exp_cnt) $display("FAIL baddev_cnt got %h want %h", cnt_wr, exp_cnt); else pass_cnt++;
    chk_cnt++;
    if (obs_q.size() != 0) $display("FAIL baddev_writes got %0d want 0", obs_q.size()); else pass_cnt++;
    chk_cnt++;
    if (err_seen - e0 != 0) $display("FAIL baddev_err got %0d want 0", err_seen - e0); else pass_cnt++;
  endtask

  task automatic test_burst();
    logic a0, a1, a2, a3, a4;
    logic [23:0] e, o;
    exp_q.push_back({16'hFFFF, 8'hAA});
    exp_q.push_back({16'h0000, 8'h55});
    exp_cnt = exp_cnt + 16'd2;
    m_start();
    m_byte(8'h78, a0); m_byte(8'hFF, a1); m_byte(8'hFF, a2); m_byte(8'hAA, a3); m_byte(8'h55, a4);
    m_stop(); settle();
    chk_cnt++;
    if ({a0, a1, a2, a3, a4} !== 5'b11111) $display("FAIL burst_acks got %b want 11111", {a0, a1, a2, a3, a4}); else pass_cnt++;
    chk_cnt++;
    if (cnt_wr !== exp_cnt) $display("FAIL burst_cnt got %h want %h", cnt_wr, exp_cnt); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs_q.size() == 0) $display("FAIL burst_write missing want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL burst_write got %h want %h", o, e); else pass_cnt++;
      end
    end
  endtask

  task automatic test_abort();
    logic a0, a1, a2, a3;
    logic [23:0] e, o;
    int e0;
    e0 = err_seen;
    m_start();
    m_byte(8'h78, a0); m_byte(8'h30, a1);
    for (int i = 0; i < 4; i++) m_bit(1'b0);
    m_stop(); settle();
    chk_cnt++;
    if (err_seen - e0 != 1) $display("FAIL abort_err got %0d want 1", err_seen - e0); else pass_cnt++;
    chk_cnt++;
    if (obs_q.size() != 0) $display("FAIL abort_writes got %0d want 0", obs_q.size()); else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else pass_cnt++;
    exp_q.push_back({16'h3008, 8'h82}); exp_cnt = exp_cnt + 16'd1;
    m_start();
    m_byte(8'h78, a0); m_byte(8'h30, a1); m_byte(8'h08, a2); m_byte(8'h82, a3);
    m_stop(); settle();
    chk_cnt++;
    if ({a0, a1, a2, a3} !== 4'b1111) $display("FAIL abort_next_acks got %b want 1111", {a0, a1, a2, a3}); else pass_cnt++;
    chk_cnt++;
    if (cnt_wr !== exp_cnt) $display("FAIL abort_next_cnt got %h want %h", cnt_wr, exp_cnt); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs_q.size() == 0) $display("FAIL abort_next_write missing want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL abort_next_write got %h want %h", o, e); else pass_cnt++;
      end
    end
  endtask

  task automatic test_read();
    logic a0, a1, a2, a3;
`ifdef SCCB_SLAVE_READ_EN
    logic [7:0] b;
    rd_data = 8'h56;
    m_start();
    m_byte(8'h78, a0); m_byte(8'h30, a1); m_byte(8'h0A, a2);
    m_start();
    m_byte(8'h79, a3);
    settle();
    chk_cnt++;
    if ({a0, a1, a2, a3} !== 4'b1111) $display("FAIL read_acks got %b want 1111", {a0, a1, a2, a3}); else pass_cnt++;
    chk_cnt++;
    if (rd_addr !== 16'h300A) $display("FAIL read_addr got %h want 300a", rd_addr); else pass_cnt++;
    m_read(1'b0, b);
    chk_cnt++;
    if (b !== 8'h56) $display("FAIL read_data got %h want 56", b); else pass_cnt++;
    m_stop(); settle();
`else
    m_start();
    m_byte(8'h79, a0);
    m_stop(); settle();
    a1 = 1'b0; a2 = 1'b0; a3 = 1'b0;
    chk_cnt++;
    if (a0 !== 1'b0) $display("FAIL read_nack got ack %b want 0", a0); else pass_cnt++;
`endif
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL read_busy got %b want 0", busy); else pass_cnt++;
    chk_cnt++;
    if (cnt_wr !== exp_cnt || obs_q.size() != 0)
      $display("FAIL read_nowrite got cnt %h/%0d want %h/0", cnt_wr, obs_q.size(), exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_ack();
    logic a0, a1, a2, a3;
    logic [23:0] e, o;
    m_start();
    m_byte(8'h78, a0);
    for (int i = 7; i >= 0; i--) m_bit(a0 ? ((8'h31 >> i) & 8'h01) != 8'h00 : 1'b0);
    wait_cyc(T/2); m_sda_lo = 1'b0;
    settle();
    chk_cnt++;
    if (sda_w !== 1'b0) $display("FAIL midack_driven got %b want 0", sda_w); else pass_cnt++;
    rst_100 = 1'b0;
    #1;
    chk_cnt++;
    if (sda_w !== 1'b1) $display("FAIL midack_release got %b want 1", sda_w); else pass_cnt++;
    chk_cnt++;
    if ({wr_valid, wr_addr, wr_data, cnt_wr, busy, err} !== 43'd0)
      $display("FAIL midack_outputs got %h want 0", {wr_valid, wr_addr, wr_data, cnt_wr, busy, err});
    else pass_cnt++;
    exp_cnt = 16'd0;
    wait_cyc(T/2); sclk = 1'b1;
    wait_cyc(T);   rst_100 = 1'b1;
    wait_cyc(T);
    exp_q.push_back({16'h1234, 8'hA5}); exp_cnt = exp_cnt + 16'd1;
    m_start();
    m_byte(8'h78, a0); m_byte(8'h12, a1); m_byte(8'h34, a2); m_byte(8'hA5, a3);
    m_stop(); settle();
    chk_cnt++;
    if ({a0, a1, a2, a3} !== 4'b1111) $display("FAIL recover_acks got %b want 1111", {a0, a1, a2, a3}); else pass_cnt++;
    chk_cnt++;
    if (cnt_wr !== exp_cnt) $display("FAIL recover_cnt got %h want %h", cnt_wr, exp_cnt); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs_q.size() == 0) $display("FAIL recover_write missing want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL recover_write got %h want %h", o, e); else pass_cnt++;
      end
    end
    chk_cnt++;
    if (overlap_seen != 0) $display("FAIL err_wr_overlap got %0d want 0", overlap_seen); else pass_cnt++;
  endtask

  initial begin
`ifdef SCCB_SLAVE_READ_EN
    rd_data = 8'h00;
`endif
    test_reset();
    test_basic_write();
    test_bad_dev();
    test_burst();
    test_abort();
    test_read();
    test_reset_mid_ack();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
